// File: rtl/cache_assoc_ctrl.sv
// cache_assoc_ctrl: two-way set-associative write-back/write-allocate cache controller with LRU and burst line fill/write-back.
// Ports:
//   iCLK, iRST_n                   clock (rising edge) and asynchronous active-low reset
//   cpu_req_*                      CPU request (valid/rw/addr/wdata) and ready, accepted only in IDLE
//   cpu_resp_valid/rdata           one-cycle response pulse with read data (writes echo the stored word)
//   mem_req_*                      one memory word at a time (we=1 write-back, we=0 fill)
//   mem_resp_ready/rdata           per-word completion pulse and fill data
// Optional: define CACHE_STATS_EN to add saturating stat_hits/stat_misses/stat_writebacks outputs.
module cache_assoc_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int WORD_W = 2
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_rw,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writebacks
`endif
);
  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - WORD_W - 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE_BACK, FILL, RESP} state_t;
  state_t state_q, state_d;
  logic rw_q, first_q, victim_q;
  logic [ADDR_W-3:0] wa_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [WORD_W-1:0] cnt_q;
  logic [1:0][SETS-1:0] valid_q, dirty_q;
  logic [SETS-1:0] lru_q;
  logic [TAG_W-1:0] tag_q [2][SETS];
  logic [DATA_W-1:0] data_q [2][1 << (IDX_W + WORD_W)];
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] idx;
  logic [WORD_W-1:0] word;
  logic hit0, hit1, hit, hit_way, vic, vic_dirty, last, wb, fill;
  logic unused_addr;
  assign unused_addr = ^cpu_req_addr[1:0];
  assign req_tag = wa_q[ADDR_W-3 -: TAG_W];
  assign idx = wa_q[IDX_W+WORD_W-1 -: IDX_W];
  assign word = wa_q[WORD_W-1:0];
  assign hit0 = valid_q[0][idx] && tag_q[0][idx] == req_tag;
  assign hit1 = valid_q[1][idx] && tag_q[1][idx] == req_tag;
  assign hit = hit0 | hit1;
  assign hit_way = ~hit0;
  // lru_q holds the least recently used way; invalid ways are always filled first
  assign vic = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign vic_dirty = valid_q[vic][idx] & dirty_q[vic][idx];
  assign last = &cnt_q;
  assign wb = state_q == WRITE_BACK;
  assign fill = state_q == FILL;
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = cpu_req_valid ? LOOKUP : IDLE;
      LOOKUP:     state_d = hit ? RESP : vic_dirty ? WRITE_BACK : FILL;
      WRITE_BACK: state_d = (mem_resp_ready && last) ? FILL : WRITE_BACK;
      FILL:       state_d = (mem_resp_ready && last) ? LOOKUP : FILL;
      RESP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    // ready is gated by reset so it reads 0 while iRST_n is held low
    cpu_req_ready = iRST_n && state_q == IDLE;
    cpu_resp_valid = state_q == RESP;
    cpu_resp_rdata = cpu_resp_valid ? rdata_q : '0;
    mem_req_valid = wb | fill;
    mem_req_we = wb;
    mem_req_addr = wb ? {tag_q[victim_q][idx], idx, cnt_q, 2'b00} : fill ? {req_tag, idx, cnt_q, 2'b00} : '0;
    mem_req_wdata = wb ? data_q[victim_q][{idx, cnt_q}] : '0;
  end
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      rw_q     <= 1'b0;
      wa_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
      victim_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      if (state_q == IDLE && cpu_req_valid) begin
        rw_q    <= cpu_req_rw;
        wa_q    <= cpu_req_addr[ADDR_W-1:2];
        wdata_q <= cpu_req_wdata;
        first_q <= 1'b1;
      end
      if (state_q == LOOKUP) begin
        first_q <= 1'b0;
        if (hit) begin
          rdata_q <= rw_q ? wdata_q : data_q[hit_way][{idx, word}];
          lru_q[idx] <= ~hit_way;
          if (rw_q) dirty_q[hit_way][idx] <= 1'b1;
        end else victim_q <= vic;
      end
      // power-of-two line length: the counter wraps to 0 after the last word
      if ((wb || fill) && mem_resp_ready) cnt_q <= cnt_q + 1'b1;
      if (fill && mem_resp_ready && last) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  always_ff @(posedge iCLK) begin
    if (state_q == LOOKUP && hit && rw_q) data_q[hit_way][{idx, word}] <= wdata_q;
    if (fill && mem_resp_ready) data_q[victim_q][{idx, cnt_q}] <= mem_resp_rdata;
    if (fill && mem_resp_ready && last) tag_q[victim_q][idx] <= req_tag;
  end
`ifdef CACHE_STATS_EN
  // the post-fill LOOKUP has first_q clear, so each request counts once
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else if (state_q == LOOKUP) begin
      if (first_q && hit && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      if (first_q && !hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      if (!hit && vic_dirty && stat_writebacks != '1) stat_writebacks <= stat_writebacks + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// tb_cache_assoc_ctrl: randomized and directed checks of cache_assoc_ctrl against a line-level LRU cache model.
module tb_cache_assoc_ctrl;
  logic iCLK = 1'b0, iRST_n = 1'b0;
  logic cpu_req_valid = 1'b0, cpu_req_rw = 1'b0;
  logic [31:0] cpu_req_addr = '0, cpu_req_wdata = '0;
  logic cpu_req_ready, cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic mem_req_valid, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic mem_resp_ready = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif
  cache_assoc_ctrl dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
  );
  always #5 iCLK = ~iCLK;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} mop_t;
  int compared = 0, mismatched = 0;
  mop_t mlog[$], exp_ops[$];
  logic [31:0] mem[int], gold[int];
  bit dty[int];
  int res[16][$];
  int m_hits = 0, m_misses = 0, m_wbs = 0;
  bit hold = 0;
  int delay = 0;
  bit exp_hit;
  logic [31:0] exp_rdata;
  function automatic logic [31:0] rd_mem(int a);
    return mem.exists(a) ? mem[a] : 32'(a);
  endfunction
  function automatic logic [31:0] rd_gold(int a);
    return gold.exists(a) ? gold[a] : 32'(a);
  endfunction
  // memory: word = address unless written back; random 0..2 wait cycles per word
  initial forever begin
    @(negedge iCLK);
    mem_resp_ready = 1'b0;
    if (!iRST_n) delay = 0;
    else if (mem_req_valid && !hold) begin
      if (delay > 0) delay--;
      else begin
        mlog.push_back({mem_req_we, mem_req_addr, mem_req_wdata});
        if (mem_req_we) mem[int'(mem_req_addr)] = mem_req_wdata;
        mem_resp_rdata = mem_req_we ? 32'h0 : rd_mem(int'(mem_req_addr));
        mem_resp_ready = 1'b1;
        delay = $urandom_range(0, 2);
      end
    end
  end
  // model: per set a list of resident line tags, oldest use first; cache data equals gold
  task automatic predict(input logic rw, input logic [31:0] a, input logic [31:0] wd);
    int set = int'((a >> 4) & 32'hF);
    int tag = int'(a >> 8);
    int line = int'(a & ~32'hF);
    int pos = -1;
    exp_ops.delete();
    foreach (res[set][j]) if (res[set][j] == tag) pos = j;
    exp_hit = pos >= 0;
    if (exp_hit) begin
      m_hits++;
      res[set].delete(pos);
    end else begin
      m_misses++;
      if (res[set].size() == 2) begin
        int vl = (res[set].pop_front() << 8) | (set << 4);
        if (dty.exists(vl)) begin
          m_wbs++;
          for (int i = 0; i < 4; i++) exp_ops.push_back({1'b1, 32'(vl + 4 * i), rd_gold(vl + 4 * i)});
          dty.delete(vl);
        end
      end
      for (int i = 0; i < 4; i++) exp_ops.push_back({1'b0, 32'(line + 4 * i), 32'h0});
    end
    res[set].push_back(tag);
    if (rw) begin
      gold[int'(a)] = wd;
      dty[line] = 1;
    end
    exp_rdata = rw ? wd : rd_gold(int'(a));
  endtask
  task automatic reset_model();
    foreach (res[i]) res[i].delete();
    dty.delete();
    gold = mem;
    m_hits = 0;
    m_misses = 0;
    m_wbs = 0;
    mlog.delete();
    exp_ops.delete();
  endtask
  task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] wd);
    int w = 0;
    while (!cpu_req_ready && w < 50) begin
      @(negedge iCLK);
      w++;
    end
    compared++;
    if (cpu_req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL issue_ready addr=%h: got %b want 1", a, cpu_req_ready);
    end
    cpu_req_valid = 1'b1;
    cpu_req_rw = rw;
    cpu_req_addr = a;
    cpu_req_wdata = wd;
    @(posedge iCLK);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_rw = $urandom_range(0, 1) == 1;
    cpu_req_addr = $urandom;
    cpu_req_wdata = $urandom;
    predict(rw, a, wd);
  endtask
  task automatic finish_req(input string nm);
    int n = 0;
    do begin
      @(negedge iCLK);
      n++;
    end while (!cpu_resp_valid && n < 500);
    compared++;
    if (cpu_resp_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL %s resp_timeout: got valid=%b want 1", nm, cpu_resp_valid);
    end else begin
      compared++;
      if (cpu_resp_rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL %s rdata: got %h want %h", nm, cpu_resp_rdata, exp_rdata);
      end
      if (exp_hit) begin
        compared++;
        if (n != 2) begin
          mismatched++;
          $display("FAIL %s hit_latency: got %0d want 2", nm, n);
        end
      end
    end
    compared++;
    if (mlog.size() != exp_ops.size()) begin
      mismatched++;
      $display("FAIL %s mem_word_count: got %0d want %0d", nm, mlog.size(), exp_ops.size());
    end else foreach (exp_ops[i]) begin
      compared++;
      if (mlog[i].we !== exp_ops[i].we || mlog[i].addr !== exp_ops[i].addr ||
          (exp_ops[i].we && mlog[i].wdata !== exp_ops[i].wdata)) begin
        mismatched++;
        $display("FAIL %s mem_word%0d: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h", nm, i,
                 mlog[i].we, mlog[i].addr, mlog[i].wdata, exp_ops[i].we, exp_ops[i].addr, exp_ops[i].wdata);
      end
    end
    mlog.delete();
`ifdef CACHE_STATS_EN
    compared++;
    if (stat_hits !== 32'(m_hits) || stat_misses !== 32'(m_misses) || stat_writebacks !== 32'(m_wbs)) begin
      mismatched++;
      $display("FAIL %s stats: got %0d/%0d/%0d want %0d/%0d/%0d", nm, stat_hits, stat_misses, stat_writebacks,
               m_hits, m_misses, m_wbs);
    end
`endif
    @(negedge iCLK);
    compared++;
    if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s back_to_idle: got ready=%b resp=%b want 1/0", nm, cpu_req_ready, cpu_resp_valid);
    end
  endtask
  task automatic check_outputs_zero(input string nm);
    compared++;
    if (cpu_req_ready !== 1'b0 || cpu_resp_valid !== 1'b0 || cpu_resp_rdata !== 32'h0 || mem_req_valid !== 1'b0 ||
        mem_req_we !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0) begin
      mismatched++;
      $display("FAIL %s outputs: got rdy=%b rv=%b rd=%h mv=%b we=%b ma=%h wd=%h want all 0", nm, cpu_req_ready,
               cpu_resp_valid, cpu_resp_rdata, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
    end
  endtask
  task automatic do_reset();
    iRST_n = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    reset_model();
    @(negedge iCLK);
  endtask
  task automatic test_reset();
    @(negedge iCLK);
    @(negedge iCLK);
    check_outputs_zero("reset");
`ifdef CACHE_STATS_EN
    compared++;
    if (stat_hits !== 0 || stat_misses !== 0 || stat_writebacks !== 0) begin
      mismatched++;
      $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_hits, stat_misses, stat_writebacks);
    end
`endif
    iRST_n = 1'b1;
    reset_model();
    @(negedge iCLK);
    compared++;
    if (cpu_req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b want 1", cpu_req_ready);
    end
  endtask
  task automatic test_cold_read();
    issue(1'b0, 32'h100, 32'h0);
    finish_req("cold_read_100");
    issue(1'b0, 32'h104, 32'h0);
    finish_req("hit_read_104");
  endtask
  task automatic test_writeback();
    issue(1'b1, 32'h100, 32'hDEADBEEF);
    finish_req("write_100");
    issue(1'b0, 32'h200, 32'h0);
    finish_req("read_200");
    issue(1'b0, 32'h300, 32'h0);
    finish_req("read_300_evict_dirty");
    issue(1'b0, 32'h100, 32'h0);
    finish_req("reread_100");
  endtask
  task automatic test_lru();
    logic [31:0] seq [5] = '{32'h100, 32'h200, 32'h100, 32'h300, 32'h100};
    do_reset();
    foreach (seq[i]) begin
      issue(1'b0, seq[i], 32'h0);
      finish_req("lru_seq");
    end
`ifdef CACHE_STATS_EN
    compared++;
    if (stat_hits !== 32'd2 || stat_misses !== 32'd3 || stat_writebacks !== 32'd0) begin
      mismatched++;
      $display("FAIL lru_stats_plan: got %0d/%0d/%0d want 2/3/0", stat_hits, stat_misses, stat_writebacks);
    end
`endif
  endtask
  task automatic test_stall();
    int w = 0;
    hold = 1;
    issue(1'b0, 32'h5C0, 32'h0);
    while (!mem_req_valid && w < 10) begin
      @(negedge iCLK);
      w++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge iCLK);
      compared++;
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h5C0 || cpu_req_ready !== 1'b0 ||
          cpu_resp_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_cycle%0d: got mv=%b we=%b ma=%h rdy=%b rv=%b want 1/0/000005c0/0/0", i, mem_req_valid,
                 mem_req_we, mem_req_addr, cpu_req_ready, cpu_resp_valid);
      end
    end
    hold = 0;
    finish_req("stall_fill");
  endtask
  task automatic test_reset_mid();
    int w = 0;
    issue(1'b0, 32'h4A0, 32'h0);
    while (mlog.size() < 2 && w < 100) begin
      @(posedge iCLK);
      #1;
      w++;
    end
    compared++;
    if (mlog.size() != 2 || mlog[0].addr !== 32'h4A0 || mlog[1].addr !== 32'h4A4) begin
      mismatched++;
      $display("FAIL reset_mid_prefix: got %0d words want 2 words 4a0,4a4", mlog.size());
    end
    iRST_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    reset_model();
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    @(negedge iCLK);
    issue(1'b0, 32'h100, 32'h0);
    finish_req("after_reset_100");
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      logic rw;
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2);
      rw = $urandom_range(0, 1) == 1;
      issue(rw, a, $urandom);
      finish_req("random");
    end
  endtask
  initial begin
    test_reset();
    test_cold_read();
    test_writeback();
    test_lru();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
